// File: rtl/hazard_pkg.sv
// Shared types and parameter checks for the hazard/forwarding unit.
// Build option: HAZ_MC_FWD_EN enables forwarding of the multi-cycle result.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_MC  = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MC_RUN  = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

   localparam int MC_LAT_MIN = 1;
   localparam int MC_LAT_MAX = 15;

   function automatic bit mc_lat_ok(input int lat);
      return (lat >= MC_LAT_MIN) && (lat <= MC_LAT_MAX);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit_mc_scoreboard.sv
// Single-entry scoreboard for an in-flight mul/div op: FSM, latency countdown
// and the ID stall term. Build option: HAZ_MC_FWD_EN.
module mc_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4,
   parameter int CNT_W  = $clog2(MC_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_mc_start,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_mc,
   output logic              mc_busy,
   output logic              mc_done,
   output logic              mc_fwd_vld,
   output logic              mc_stall,
   output logic [REG_AW-1:0] mc_rd
);

   if (!mc_lat_ok(MC_LAT)) begin : g_bad_lat
      $error("mc_scoreboard: MC_LAT %0d outside legal range", MC_LAT);
   end

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MC_LAT - 1);

   mc_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_AW-1:0] mc_rd_q, mc_rd_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mc_rd_d = mc_rd_q;
      case (state_q)
         IDLE: begin
            if (ex_mc_start) begin
               state_d = MC_RUN;
               cnt_d   = LAT_M1;
               mc_rd_d = ex_rd;
            end
         end
         // a start seen here is illegal and simply dropped
         MC_RUN: begin
            if (cnt_q == '0) state_d = MC_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         MC_DONE: begin
            if (ex_mc_start) begin
               state_d = MC_RUN;
               cnt_d   = LAT_M1;
               mc_rd_d = ex_rd;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mc_rd_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mc_rd_q <= mc_rd_d;
      end
   end

   logic rd_nz, raw, waw, run_stall, done_stall;

   always_comb begin
      rd_nz     = (mc_rd_q != '0);
      raw       = rd_nz && ((id_rs1 == mc_rd_q) || (id_rs2 == mc_rd_q));
      waw       = id_regwrite && (id_rd == mc_rd_q);
      run_stall = raw || waw || id_mc;
`ifdef HAZ_MC_FWD_EN
      done_stall = 1'b0;
      mc_fwd_vld = !rst && (state_q == MC_DONE) && rd_nz;
`else
      // without the bypass, readers wait for the writeback and read the regfile
      done_stall = raw;
      mc_fwd_vld = 1'b0;
`endif
      mc_stall = !rst && id_valid &&
                 (((state_q == MC_RUN) && run_stall) ||
                  ((state_q == MC_DONE) && done_stall));
      mc_busy  = !rst && (state_q != IDLE);
      mc_done  = !rst && (state_q == MC_DONE);
      mc_rd    = rst ? '0 : mc_rd_q;
   end

`ifndef SYNTHESIS
   a_no_start_in_run: assert property (@(posedge clk) disable iff (rst)
      !(ex_mc_start && (state_q == MC_RUN)))
      else $error("mc_scoreboard: ex_mc_start during MC_RUN ignored");
`endif

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding, load-use detection and multi-cycle scoreboard hookup.
// Build option: HAZ_MC_FWD_EN (multi-cycle result bypass, code 11).
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4,
   parameter int CNT_W  = $clog2(MC_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_mc,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic              ex_mc_start,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              mem_regwrite,
   input  logic              wb_regwrite,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              hz_stall,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [REG_AW-1:0] mc_rd
);

   logic mc_fwd_vld, mc_stall, load_use;

   // EX write enable does not affect any hazard decision here
   logic unused_ex_regwrite;
   assign unused_ex_regwrite = ex_regwrite;

   mc_scoreboard #(
      .REG_AW (REG_AW),
      .MC_LAT (MC_LAT),
      .CNT_W  (CNT_W)
   ) u_mc_sb (
      .clk         (clk),
      .rst         (rst),
      .ex_mc_start (ex_mc_start),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_mc       (id_mc),
      .mc_busy     (mc_busy),
      .mc_done     (mc_done),
      .mc_fwd_vld  (mc_fwd_vld),
      .mc_stall    (mc_stall),
      .mc_rd       (mc_rd)
   );

   // MC sits below MEM/WB: the WAW stall guarantees no younger writer of mc_rd
   function automatic fwd_sel_e fwd_pick(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] m_rd,
      input logic              m_we,
      input logic [REG_AW-1:0] w_rd,
      input logic              w_we,
      input logic              c_vld,
      input logic [REG_AW-1:0] c_rd
   );
      fwd_sel_e sel;
      sel = FWD_RF;
      if (m_we && (m_rd != '0) && (m_rd == rs))      sel = FWD_MEM;
      else if (w_we && (w_rd != '0) && (w_rd == rs)) sel = FWD_WB;
      else if (c_vld && (c_rd == rs))                sel = FWD_MC;
      return sel;
   endfunction

   always_comb begin
      fwd_a    = FWD_RF;
      fwd_b    = FWD_RF;
      load_use = id_valid && ex_memread && (ex_rd != '0) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      if (!rst) begin
         fwd_a = fwd_pick(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite, mc_fwd_vld, mc_rd);
         fwd_b = fwd_pick(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite, mc_fwd_vld, mc_rd);
      end
      hz_stall = !rst && (load_use || mc_stall);
   end

endmodule
